// File: rtl/intr_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : intr_controller_if                                     |
// | Description : CPU <-> interrupt controller signal bundle. The CPU    |
// |               side (master) drives requests and control strobes;     |
// |               the controller side (slave) returns dispatch state.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface intr_controller_if #(
    parameter int ADDR_W = 10
);
    logic [1:0]        irq;
    logic [1:0]        mask;
    logic              gie_set;
    logic              gie_clr;
    logic              reti;
    logic [ADDR_W-1:0] vec0;
    logic [ADDR_W-1:0] vec1;
    logic [ADDR_W-1:0] pc_cur;

    logic              take;
    logic [ADDR_W-1:0] vector;
    logic [ADDR_W-1:0] push_addr;
    logic [1:0]        pending;
    logic [1:0]        in_service;
    logic              gie;
    logic [1:0]        lost;

    modport master (
        output irq, mask, gie_set, gie_clr, reti, vec0, vec1, pc_cur,
        input  take, vector, push_addr, pending, in_service, gie, lost
    );

    modport slave (
        input  irq, mask, gie_set, gie_clr, reti, vec0, vec1, pc_cur,
        output take, vector, push_addr, pending, in_service, gie, lost
    );
endinterface
`default_nettype wire

// File: rtl/intr_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : intr_controller                                        |
// | Description : Two-source vectored interrupt controller. Edge-detects |
// |               timer/external requests, latches them as pending,      |
// |               arbitrates with timer priority and issues a one-cycle  |
// |               registered take pulse. No nesting: gie is held low     |
// |               from dispatch until return-from-interrupt.             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module intr_controller #(
    parameter int ADDR_W = 10
) (
    input  wire logic          clk,
    input  wire logic          reset,
    intr_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        SERVICE  = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        irq_d;
    logic              take_reg;
    logic [ADDR_W-1:0] vector_reg;
    logic [1:0]        pending_reg;
    logic [1:0]        in_service_reg;
    logic              gie_reg;
    logic [1:0]        lost_reg;

    logic [1:0]        rise;
    logic [1:0]        eligible;
    logic [1:0]        win_onehot;
    logic [ADDR_W-1:0] win_vector;
    logic              dispatch;
    logic [1:0]        pend_clr;

    // Request edge detection, eligibility and fixed-priority winner (timer first)
    always_comb begin
        rise       = bus.irq & ~irq_d;
        eligible   = pending_reg & bus.mask;
        win_onehot = eligible[0] ? 2'b01 : 2'b10;
        win_vector = eligible[0] ? bus.vec0 : bus.vec1;
        // reti blocks dispatch so one handler-return instruction always completes
        dispatch   = (state == IDLE) && gie_reg && (eligible != 2'b00) && !bus.reti;
        pend_clr   = dispatch ? win_onehot : 2'b00;
    end

    // Dispatch FSM with all outputs registered; reset aborts any handler state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            irq_d          <= 2'b00;
            take_reg       <= 1'b0;
            vector_reg     <= '0;
            pending_reg    <= 2'b00;
            in_service_reg <= 2'b00;
            gie_reg        <= 1'b0;
            lost_reg       <= 2'b00;
        end else begin
            irq_d       <= bus.irq;
            // A new edge wins over the dispatch clear of the same source
            pending_reg <= (pending_reg & ~pend_clr) | rise;
            // Only count as lost if the pending bit survives this edge
            lost_reg    <= lost_reg | (rise & pending_reg & ~pend_clr);
            take_reg    <= 1'b0;

            case (state)
                IDLE: begin
                    if (dispatch) begin
                        state          <= DISPATCH;
                        take_reg       <= 1'b1;
                        vector_reg     <= win_vector;
                        in_service_reg <= win_onehot;
                        gie_reg        <= 1'b0;
                    end else if (bus.gie_clr) begin
                        gie_reg <= 1'b0;
                    end else if (bus.gie_set) begin
                        gie_reg <= 1'b1;
                    end
                end
                DISPATCH: begin
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (bus.reti) begin
                        state          <= IDLE;
                        in_service_reg <= 2'b00;
                        gie_reg        <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.take       = take_reg;
    assign bus.vector     = vector_reg;
    assign bus.push_addr  = take_reg ? bus.pc_cur : '0;
    assign bus.pending    = pending_reg;
    assign bus.in_service = in_service_reg;
    assign bus.gie        = gie_reg;
    assign bus.lost       = lost_reg;

endmodule
`default_nettype wire

// File: tb/tb_intr_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_intr_controller                                     |
// | Description : Directed vector bench for intr_controller.             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_intr_controller;

    localparam int ADDR_W = 10;
    localparam int NROWS  = 31;

    logic clk;
    logic reset;

    intr_controller_if #(.ADDR_W(ADDR_W)) bus ();

    intr_controller #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        irq;
        logic [1:0]        mask;
        logic              gs;
        logic              gc;
        logic              rt;
        logic [ADDR_W-1:0] pc;
        logic              take;
        logic [ADDR_W-1:0] vec;
        logic [1:0]        pend;
        logic [1:0]        isv;
        logic              gie;
        logic [1:0]        lost;
    } row_t;

    row_t tbl [NROWS];
    int   checks;
    int   errors;

    function automatic row_t mk(input logic [1:0] irq, input logic [1:0] mask,
                                input logic gs, input logic gc, input logic rt,
                                input logic [ADDR_W-1:0] pc, input logic take,
                                input logic [ADDR_W-1:0] vec, input logic [1:0] pend,
                                input logic [1:0] isv, input logic gie,
                                input logic [1:0] lost);
        row_t r;
        r.irq = irq; r.mask = mask; r.gs = gs; r.gc = gc; r.rt = rt; r.pc = pc;
        r.take = take; r.vec = vec; r.pend = pend; r.isv = isv; r.gie = gie; r.lost = lost;
        return r;
    endfunction

    // Packs observable outputs; vector only meaningful while take is high
    function automatic logic [27:0] observe();
        return {bus.take, (bus.take ? bus.vector : 10'h000), bus.push_addr,
                bus.pending, bus.in_service, bus.gie, bus.lost};
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got take/vec/push/pend/isv/gie/lost=%h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input row_t r);
        bus.irq     = r.irq;
        bus.mask    = r.mask;
        bus.gie_set = r.gs;
        bus.gie_clr = r.gc;
        bus.reti    = r.rt;
        bus.pc_cur  = r.pc;
    endtask

    initial begin
        logic [27:0] exp;

        // row: irq mask gs gc rt pc | take vec pend isv gie lost
        tbl[0]  = mk(2'b00, 2'b11, 1, 0, 0, 10'h000, 0, 10'h000, 2'b00, 2'b00, 1, 2'b00);
        tbl[1]  = mk(2'b01, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b01, 2'b00, 1, 2'b00);
        tbl[2]  = mk(2'b01, 2'b11, 0, 0, 0, 10'h055, 1, 10'h100, 2'b00, 2'b01, 0, 2'b00);
        tbl[3]  = mk(2'b00, 2'b11, 0, 0, 0, 10'h056, 0, 10'h000, 2'b00, 2'b01, 0, 2'b00);
        tbl[4]  = mk(2'b00, 2'b11, 0, 0, 1, 10'h000, 0, 10'h000, 2'b00, 2'b00, 1, 2'b00);
        tbl[5]  = mk(2'b00, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b00, 2'b00, 1, 2'b00);
        tbl[6]  = mk(2'b11, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b11, 2'b00, 1, 2'b00);
        tbl[7]  = mk(2'b11, 2'b11, 0, 0, 0, 10'h0AA, 1, 10'h100, 2'b10, 2'b01, 0, 2'b00);
        tbl[8]  = mk(2'b00, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b10, 2'b01, 0, 2'b00);
        tbl[9]  = mk(2'b00, 2'b11, 0, 0, 1, 10'h000, 0, 10'h000, 2'b10, 2'b00, 1, 2'b00);
        tbl[10] = mk(2'b00, 2'b11, 0, 0, 0, 10'h0BB, 1, 10'h200, 2'b00, 2'b10, 0, 2'b00);
        tbl[11] = mk(2'b00, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b00, 2'b10, 0, 2'b00);
        tbl[12] = mk(2'b01, 2'b10, 0, 0, 0, 10'h000, 0, 10'h000, 2'b01, 2'b10, 0, 2'b00);
        tbl[13] = mk(2'b10, 2'b10, 0, 0, 0, 10'h000, 0, 10'h000, 2'b11, 2'b10, 0, 2'b00);
        tbl[14] = mk(2'b00, 2'b00, 0, 0, 1, 10'h000, 0, 10'h000, 2'b11, 2'b00, 1, 2'b00);
        tbl[15] = mk(2'b00, 2'b00, 0, 0, 0, 10'h000, 0, 10'h000, 2'b11, 2'b00, 1, 2'b00);
        tbl[16] = mk(2'b00, 2'b11, 0, 0, 0, 10'h0CC, 1, 10'h100, 2'b10, 2'b01, 0, 2'b00);
        tbl[17] = mk(2'b00, 2'b11, 1, 0, 0, 10'h000, 0, 10'h000, 2'b10, 2'b01, 0, 2'b00);
        tbl[18] = mk(2'b00, 2'b00, 0, 0, 1, 10'h000, 0, 10'h000, 2'b10, 2'b00, 1, 2'b00);
        tbl[19] = mk(2'b00, 2'b00, 0, 1, 0, 10'h000, 0, 10'h000, 2'b10, 2'b00, 0, 2'b00);
        tbl[20] = mk(2'b00, 2'b11, 1, 1, 0, 10'h000, 0, 10'h000, 2'b10, 2'b00, 0, 2'b00);
        tbl[21] = mk(2'b00, 2'b11, 0, 0, 1, 10'h000, 0, 10'h000, 2'b10, 2'b00, 0, 2'b00);
        tbl[22] = mk(2'b01, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b11, 2'b00, 0, 2'b00);
        tbl[23] = mk(2'b00, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b11, 2'b00, 0, 2'b00);
        tbl[24] = mk(2'b01, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b11, 2'b00, 0, 2'b01);
        tbl[25] = mk(2'b00, 2'b11, 1, 0, 0, 10'h000, 0, 10'h000, 2'b11, 2'b00, 1, 2'b01);
        tbl[26] = mk(2'b01, 2'b11, 0, 0, 0, 10'h0DD, 1, 10'h100, 2'b11, 2'b01, 0, 2'b01);
        tbl[27] = mk(2'b00, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b11, 2'b01, 0, 2'b01);
        tbl[28] = mk(2'b00, 2'b11, 0, 0, 1, 10'h000, 0, 10'h000, 2'b11, 2'b00, 1, 2'b01);
        tbl[29] = mk(2'b00, 2'b11, 0, 0, 0, 10'h0EE, 1, 10'h100, 2'b10, 2'b01, 0, 2'b01);
        tbl[30] = mk(2'b00, 2'b11, 0, 0, 0, 10'h000, 0, 10'h000, 2'b10, 2'b01, 0, 2'b01);

        checks = 0;
        errors = 0;

        bus.vec0 = 10'h100;
        bus.vec1 = 10'h200;
        drive(mk(2'b00, 2'b11, 0, 0, 0, 10'h3FF, 0, 10'h000, 2'b00, 2'b00, 0, 2'b00));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", observe(), 28'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven sequence: inputs at negedge, outputs checked just after posedge
        for (int i = 0; i < NROWS; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            exp = {tbl[i].take, (tbl[i].take ? tbl[i].vec : 10'h000),
                   (tbl[i].take ? tbl[i].pc : 10'h000),
                   tbl[i].pend, tbl[i].isv, tbl[i].gie, tbl[i].lost};
            check($sformatf("row%0d", i), observe(), exp);
        end

        // Asynchronous reset in the middle of a SERVICE cycle
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", observe(), 28'h0);
        @(negedge clk);
        drive(mk(2'b00, 2'b11, 0, 0, 0, 10'h123, 0, 10'h000, 2'b00, 2'b00, 0, 2'b00));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset_idle%0d", k), observe(), 28'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intr_controller.md
# intr_controller

Two-source vectored interrupt controller for the single-cycle CPU. It edge-detects the timer tick and an external request line, latches them as pending, and arbitrates by fixed priority. When the global enable allows, it issues a one-cycle `take` pulse that steers the PC mux to the selected vector and pushes the interrupted PC onto the return stack. It tracks the in-service source until the CPU executes a return-from-interrupt.

## Interface
- `ADDR_W`, default 10: width of instruction addresses (PC, vectors, stack entries).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  reset, asynchronous, active-high; clock clk.
- `irq`  in  2  request lines. Bit 0 is the timer tick and bit 1 is the external source. Active on a rising edge.
- `mask`  in  2  per-source enable; 1 = may be dispatched.
- `gie_set`  in  1  enable-interrupts instruction executing this cycle.
- `gie_clr`  in  1  disable-interrupts instruction executing this cycle.
- `reti`  in  1  return-from-interrupt instruction executing this cycle.
- `vec0`, `vec1`  in  ADDR_W  handler addresses for source 0 and source 1.
- `pc_cur`  in  ADDR_W  address of the instruction at the PC this cycle.
- `take`  out  1  one-cycle dispatch pulse. Drives PC-mux select and stack push.
- `vector`  out  ADDR_W  handler address; valid while `take`=1.
- `push_addr`  out  ADDR_W  value to push; equals `pc_cur` while `take`=1.
- `pending`  out  2  latched, not-yet-dispatched requests.
- `in_service`  out  2  one-hot source being serviced; 0 when idle.
- `gie`  out  1  global interrupt enable.
- `lost`  out  2  sticky flag per source: an edge arrived while that source was already pending.

## Operation
- **Edge detect:** a registered copy `irq_d` is kept. A rising edge on source i means `irq[i] & ~irq_d[i]`. An edge sets `pending[i]`; the `mask` value does not affect latching.
- **Lost requests:** an edge on a source whose `pending` bit is already set sets `lost[i]`. `lost` clears only on reset.
- **Eligibility and priority:** `eligible = pending & mask`. Source 0 (timer) beats source 1.
- **State machine:**
  - IDLE: if `gie`=1, `eligible`≠0 and `reti`=0, go to DISPATCH. In the same edge:
    - register the winning source's vector into `vector`;
    - set the one-hot `in_service` bit;
    - clear that source's `pending` bit.
  - DISPATCH: lasts exactly one cycle with `take`=1, then go to SERVICE. On entry `gie` is forced to 0, so there is no nesting.
  - SERVICE: stays until `reti`=1. On that edge go to IDLE, clear `in_service` and set `gie`=1.
- **CPU-side rules during `take`=1:** the CPU suppresses regfile, data-memory and flag writes for the instruction at `pc_cur`. It pushes `pc_cur`, so that instruction re-executes after `reti`.
- **`gie` updates:** `gie_set` sets it and `gie_clr` clears it. If both are asserted, clear wins. Both are ignored in DISPATCH. In SERVICE, `gie_set` is ignored and `gie` stays 0.
- **`reti` outside SERVICE:** ignored.
- **Pending set vs clear:** if a source's pending bit is cleared by dispatch in the same edge that a new edge arrives on that source, the set wins. The bit stays 1 and `lost` is not set.
- **Masking:** a masked pending request remains pending indefinitely. It is dispatched once unmasked.
- **Reset values (all outputs):** state IDLE, `take`=0, `vector`=0, `pending`=0, `in_service`=0, `gie`=0, `lost`=0, `irq_d`=0.
- **Reset mid-operation:** reset asserted during DISPATCH or SERVICE aborts immediately to these values.

## Timing
- Edge on `irq` sampled at clock edge E0 → `pending` set after E0.
- If eligible at E1 → `take`=1 and `vector` valid for the cycle between E1 and E2.
- Total request-to-`take` latency is 2 edges minimum.
- `take` is a registered output; it is never combinational from `irq`.
- `push_addr` is a combinational pass-through of `pc_cur`, gated to 0 when `take`=0.
- `reti` at edge En → IDLE after En. The earliest next `take` follows edge En+1, so at least one handler-return instruction completes between ISRs.

## Test plan
- **Basic timer dispatch:** `vec0`=0x100, `gie_set` pulse, then one rising edge on `irq[0]` → `pending`=01 after the sampling edge. `take`=1 for exactly one cycle, with `vector`=0x100 and `push_addr`=`pc_cur`. Afterwards `in_service`=01, `gie`=0, `pending`=00.
- **Priority:** both `irq` bits rise in the same cycle with `vec1`=0x200 → timer is dispatched first (0x100). After `reti`, `gie` returns to 1. One cycle later, a second `take` occurs with `vector`=0x200.
- **Masking and no nesting:** `mask`=10 and `irq[0]` edge → `pending`=01, no `take`. Then an `irq[1]` edge arrives during SERVICE of source 1 → no `take` until `reti`. Setting `mask`=11 after return → source 0 is dispatched.
- **Lost flag:** `gie`=0 and two `irq[0]` edges → `lost`=01, `pending`=01. An edge coinciding with its own dispatch clear → `pending` stays 01 and `lost` is unchanged.
- **gie conflicts:** `gie_set` and `gie_clr` together → `gie`=0. `reti` while idle → no state change.
- **Reset mid-service:** assert `reset` asynchronously between clock edges during SERVICE → all outputs reach reset values immediately, and no `take` appears after release.
